// File: rtl/instr_encoder.sv
// RV64I/Zba instruction encoder feeding a 2-entry output FIFO; malformed requests push a zero word flagged err.
// Optional Zba encodings (ops 49-56) are enabled by defining INSTR_ENCODER_ZBA_EN.
module instr_encoder #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic              out_err,
    output logic [15:0]       out_count,
    output logic [7:0]        err_count
);

    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
        OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
        OP_SH1ADD, OP_SH2ADD, OP_SH3ADD, OP_ADD_UW,
        OP_SH1ADD_UW, OP_SH2ADD_UW, OP_SH3ADD_UW, OP_SLLI_UW,
        OP_ECALL
    } op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM32  = 7'b0011011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {im, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] opc);
        return {im[11:5], rs2, rs1, f3, im[4:0], opc};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:1] im, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:1] im, input logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, OPC_JAL};
    endfunction

    function automatic logic fit_i(input logic signed [31:0] v);
        return (v >= -32'sd2048) && (v <= 32'sd2047);
    endfunction

    function automatic logic fit_b(input logic signed [31:0] v);
        return !v[0] && (v >= -32'sd4096) && (v <= 32'sd4094);
    endfunction

    function automatic logic fit_j(input logic signed [31:0] v);
        return !v[0] && (v >= -32'sd1048576) && (v <= 32'sd1048574);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic signed [31:0] imm_s;
    logic [31:0]        enc;
    logic               bad;
    logic               sh6_bad;
    logic               sh5_bad;
    logic [DATA_W-1:0]  instr_p0;
    logic               err_p0;
    logic               vld_p0;

    assign imm_s   = req_imm;
    assign sh6_bad = (req_imm[31:6] != 26'd0);
    assign sh5_bad = (req_imm[31:5] != 27'd0);

    always_comb begin
        enc = 32'h0;
        bad = 1'b0;
        case (req_op)
            OP_LUI:   begin enc = {req_imm[31:12], req_rd, OPC_LUI};   bad = (req_imm[11:0] != 12'd0); end
            OP_AUIPC: begin enc = {req_imm[31:12], req_rd, OPC_AUIPC}; bad = (req_imm[11:0] != 12'd0); end
            OP_JAL:   begin enc = enc_j(req_imm[20:1], req_rd); bad = !fit_j(imm_s); end
            OP_JALR:  begin enc = enc_i(req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_JALR); bad = !fit_i(imm_s); end
            OP_BEQ:   begin enc = enc_b(req_imm[12:1], req_rs2, req_rs1, 3'b000); bad = !fit_b(imm_s); end
            OP_BNE:   begin enc = enc_b(req_imm[12:1], req_rs2, req_rs1, 3'b001); bad = !fit_b(imm_s); end
            OP_BLT:   begin enc = enc_b(req_imm[12:1], req_rs2, req_rs1, 3'b100); bad = !fit_b(imm_s); end
            OP_BGE:   begin enc = enc_b(req_imm[12:1], req_rs2, req_rs1, 3'b101); bad = !fit_b(imm_s); end
            OP_BLTU:  begin enc = enc_b(req_imm[12:1], req_rs2, req_rs1, 3'b110); bad = !fit_b(imm_s); end
            OP_BGEU:  begin enc = enc_b(req_imm[12:1], req_rs2, req_rs1, 3'b111); bad = !fit_b(imm_s); end
            OP_LB:    begin enc = enc_i(req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_LOAD); bad = !fit_i(imm_s); end
            OP_LH:    begin enc = enc_i(req_imm[11:0], req_rs1, 3'b001, req_rd, OPC_LOAD); bad = !fit_i(imm_s); end
            OP_LW:    begin enc = enc_i(req_imm[11:0], req_rs1, 3'b010, req_rd, OPC_LOAD); bad = !fit_i(imm_s); end
            OP_LD:    begin enc = enc_i(req_imm[11:0], req_rs1, 3'b011, req_rd, OPC_LOAD); bad = !fit_i(imm_s); end
            OP_LBU:   begin enc = enc_i(req_imm[11:0], req_rs1, 3'b100, req_rd, OPC_LOAD); bad = !fit_i(imm_s); end
            OP_LHU:   begin enc = enc_i(req_imm[11:0], req_rs1, 3'b101, req_rd, OPC_LOAD); bad = !fit_i(imm_s); end
            OP_LWU:   begin enc = enc_i(req_imm[11:0], req_rs1, 3'b110, req_rd, OPC_LOAD); bad = !fit_i(imm_s); end
            OP_SB:    begin enc = enc_s(req_imm[11:0], req_rs2, req_rs1, 3'b000, OPC_STORE); bad = !fit_i(imm_s); end
            OP_SH:    begin enc = enc_s(req_imm[11:0], req_rs2, req_rs1, 3'b001, OPC_STORE); bad = !fit_i(imm_s); end
            OP_SW:    begin enc = enc_s(req_imm[11:0], req_rs2, req_rs1, 3'b010, OPC_STORE); bad = !fit_i(imm_s); end
            OP_SD:    begin enc = enc_s(req_imm[11:0], req_rs2, req_rs1, 3'b011, OPC_STORE); bad = !fit_i(imm_s); end
            OP_ADDI:  begin enc = enc_i(req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_IMM); bad = !fit_i(imm_s); end
            OP_SLTI:  begin enc = enc_i(req_imm[11:0], req_rs1, 3'b010, req_rd, OPC_IMM); bad = !fit_i(imm_s); end
            OP_SLTIU: begin enc = enc_i(req_imm[11:0], req_rs1, 3'b011, req_rd, OPC_IMM); bad = !fit_i(imm_s); end
            OP_XORI:  begin enc = enc_i(req_imm[11:0], req_rs1, 3'b100, req_rd, OPC_IMM); bad = !fit_i(imm_s); end
            OP_ORI:   begin enc = enc_i(req_imm[11:0], req_rs1, 3'b110, req_rd, OPC_IMM); bad = !fit_i(imm_s); end
            OP_ANDI:  begin enc = enc_i(req_imm[11:0], req_rs1, 3'b111, req_rd, OPC_IMM); bad = !fit_i(imm_s); end
            // RV64 shifts carry a 6-bit shamt under a 6-bit funct6
            OP_SLLI:  begin enc = enc_i({6'b000000, req_imm[5:0]}, req_rs1, 3'b001, req_rd, OPC_IMM); bad = sh6_bad; end
            OP_SRLI:  begin enc = enc_i({6'b000000, req_imm[5:0]}, req_rs1, 3'b101, req_rd, OPC_IMM); bad = sh6_bad; end
            OP_SRAI:  begin enc = enc_i({6'b010000, req_imm[5:0]}, req_rs1, 3'b101, req_rd, OPC_IMM); bad = sh6_bad; end
            OP_ADD:   enc = enc_r(7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, OPC_OP);
            OP_SUB:   enc = enc_r(7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, OPC_OP);
            OP_SLL:   enc = enc_r(7'b0000000, req_rs2, req_rs1, 3'b001, req_rd, OPC_OP);
            OP_SLT:   enc = enc_r(7'b0000000, req_rs2, req_rs1, 3'b010, req_rd, OPC_OP);
            OP_SLTU:  enc = enc_r(7'b0000000, req_rs2, req_rs1, 3'b011, req_rd, OPC_OP);
            OP_XOR:   enc = enc_r(7'b0000000, req_rs2, req_rs1, 3'b100, req_rd, OPC_OP);
            OP_SRL:   enc = enc_r(7'b0000000, req_rs2, req_rs1, 3'b101, req_rd, OPC_OP);
            OP_SRA:   enc = enc_r(7'b0100000, req_rs2, req_rs1, 3'b101, req_rd, OPC_OP);
            OP_OR:    enc = enc_r(7'b0000000, req_rs2, req_rs1, 3'b110, req_rd, OPC_OP);
            OP_AND:   enc = enc_r(7'b0000000, req_rs2, req_rs1, 3'b111, req_rd, OPC_OP);
            OP_ADDIW: begin enc = enc_i(req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_IMM32); bad = !fit_i(imm_s); end
            OP_SLLIW: begin enc = enc_r(7'b0000000, req_imm[4:0], req_rs1, 3'b001, req_rd, OPC_IMM32); bad = sh5_bad; end
            OP_SRLIW: begin enc = enc_r(7'b0000000, req_imm[4:0], req_rs1, 3'b101, req_rd, OPC_IMM32); bad = sh5_bad; end
            OP_SRAIW: begin enc = enc_r(7'b0100000, req_imm[4:0], req_rs1, 3'b101, req_rd, OPC_IMM32); bad = sh5_bad; end
            OP_ADDW:  enc = enc_r(7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, OPC_OP32);
            OP_SUBW:  enc = enc_r(7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, OPC_OP32);
            OP_SLLW:  enc = enc_r(7'b0000000, req_rs2, req_rs1, 3'b001, req_rd, OPC_OP32);
            OP_SRLW:  enc = enc_r(7'b0000000, req_rs2, req_rs1, 3'b101, req_rd, OPC_OP32);
            OP_SRAW:  enc = enc_r(7'b0100000, req_rs2, req_rs1, 3'b101, req_rd, OPC_OP32);
`ifdef INSTR_ENCODER_ZBA_EN
            OP_SH1ADD:    enc = enc_r(7'b0010000, req_rs2, req_rs1, 3'b010, req_rd, OPC_OP);
            OP_SH2ADD:    enc = enc_r(7'b0010000, req_rs2, req_rs1, 3'b100, req_rd, OPC_OP);
            OP_SH3ADD:    enc = enc_r(7'b0010000, req_rs2, req_rs1, 3'b110, req_rd, OPC_OP);
            OP_ADD_UW:    enc = enc_r(7'b0000100, req_rs2, req_rs1, 3'b000, req_rd, OPC_OP32);
            OP_SH1ADD_UW: enc = enc_r(7'b0010000, req_rs2, req_rs1, 3'b010, req_rd, OPC_OP32);
            OP_SH2ADD_UW: enc = enc_r(7'b0010000, req_rs2, req_rs1, 3'b100, req_rd, OPC_OP32);
            OP_SH3ADD_UW: enc = enc_r(7'b0010000, req_rs2, req_rs1, 3'b110, req_rd, OPC_OP32);
            OP_SLLI_UW:   begin enc = enc_i({6'b000010, req_imm[5:0]}, req_rs1, 3'b001, req_rd, OPC_IMM32); bad = sh6_bad; end
`else
`endif
            OP_ECALL: enc = 32'h0000_0073;
            default:  bad = 1'b1;
        endcase
    end

    assign instr_p0 = bad ? '0 : enc;
    assign err_p0   = bad;
    assign vld_p0   = req_valid && req_ready;

    // ---- stage p1: 2-entry FIFO, payload unreset, control reset ----
    logic [DATA_W-1:0] instr_p1 [2];
    logic              err_p1   [2];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [1:0]        occ;
    logic              pop;

    assign req_ready = !rst && (occ != 2'd2);
    assign out_valid = !rst && (occ != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? instr_p1[rd_ptr[0]] : '0;
    assign out_err   = out_valid ? err_p1[rd_ptr[0]] : 1'b0;

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            instr_p1[wr_ptr[0]] <= instr_p0;
            err_p1[wr_ptr[0]]   <= err_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            occ       <= 2'd0;
            out_count <= 16'd0;
            err_count <= 8'd0;
        end else begin
            if (vld_p0) wr_ptr <= (wr_ptr == 2'd1) ? 2'd0 : wr_ptr + 2'd1;
            if (pop)    rd_ptr <= (rd_ptr == 2'd1) ? 2'd0 : rd_ptr + 2'd1;
            occ <= occ + {1'b0, vld_p0} - {1'b0, pop};
            if (pop)             out_count <= out_count + 16'd1;
            if (vld_p0 && err_p0) err_count <= sat_inc8(err_count);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed encodings, rejections, FIFO backpressure and reset.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] out_count;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_out  = 0;
    int exp_errs = 0;

    instr_encoder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
        .out_count(out_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    endtask

    // Push one request into an empty FIFO, check the head, pop it and check the counters.
    task automatic xact(input string tag, input logic [5:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_instr, input logic exp_err);
        set_req(op, rd, rs1, rs2, imm);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, " instr"}, out_instr, exp_instr);
        check({tag, " err"}, {31'd0, out_err}, {31'd0, exp_err});
        if (exp_err) exp_errs = (exp_errs == 255) ? 255 : exp_errs + 1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_out++;
        check({tag, " out_count"}, {16'd0, out_count}, exp_out);
        check({tag, " err_count"}, {24'd0, err_count}, exp_errs);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; out_ready = 1'b0;
        set_req(6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst req_ready", {31'd0, req_ready}, 32'd0);
        check("rst out_instr", out_instr, 32'd0);
        check("rst out_err", {31'd0, out_err}, 32'd0);
        check("rst out_count", {16'd0, out_count}, 32'd0);
        check("rst err_count", {24'd0, err_count}, 32'd0);
        rst = 1'b0;
        #1;
        check("post-rst req_ready", {31'd0, req_ready}, 32'd1);

        // ADDI, with no combinational path before the clock edge
        set_req(6'd21, 5'd1, 5'd0, 5'd0, 32'd5);
        req_valid = 1'b1;
        #1;
        check("no comb path", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("addi valid", {31'd0, out_valid}, 32'd1);
        check("addi instr", out_instr, 32'h0050_0093);
        check("addi err", {31'd0, out_err}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_out++;
        check("addi drained", {31'd0, out_valid}, 32'd0);
        check("addi out_count", {16'd0, out_count}, exp_out);

        xact("beq -4",    6'd4,  5'd0, 5'd1, 5'd2, -32'sd4,      32'hFE20_8EE3, 1'b0);
        xact("beq odd",   6'd4,  5'd0, 5'd1, 5'd2, 32'd3,        32'h0,         1'b1);
        xact("lui",       6'd0,  5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        xact("lui low",   6'd0,  5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h0,         1'b1);
        xact("jal",       6'd2,  5'd1, 5'd0, 5'd0, 32'd2048,     32'h0010_00EF, 1'b0);
        xact("sd",        6'd20, 5'd0, 5'd2, 5'd8, 32'd16,       32'h0081_3823, 1'b0);
        xact("srai 63",   6'd29, 5'd1, 5'd1, 5'd0, 32'd63,       32'h43F0_D093, 1'b0);
        xact("slliw 32",  6'd41, 5'd1, 5'd1, 5'd0, 32'd32,       32'h0,         1'b1);
        xact("sub",       6'd31, 5'd3, 5'd1, 5'd2, 32'd0,        32'h4020_81B3, 1'b0);
        xact("ecall",     6'd57, 5'd5, 5'd3, 5'd4, 32'd7,        32'h0000_0073, 1'b0);
        xact("addi 2048", 6'd21, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h0,         1'b1);
        xact("reserved",  6'd60, 5'd1, 5'd1, 5'd1, 32'd0,        32'h0,         1'b1);
`ifdef INSTR_ENCODER_ZBA_EN
        xact("sh1add",    6'd49, 5'd3, 5'd1, 5'd2, 32'd0,        32'h2020_A1B3, 1'b0);
`else
        xact("sh1add",    6'd49, 5'd3, 5'd1, 5'd2, 32'd0,        32'h0,         1'b1);
`endif

        // Backpressure: A, B fill the FIFO, C waits; then drain in order
        out_ready = 1'b0;
        set_req(6'd21, 5'd1, 5'd0, 5'd0, 32'd1);
        req_valid = 1'b1;
        @(posedge clk); #1;
        check("fill1 ready", {31'd0, req_ready}, 32'd1);
        check("fill1 head", out_instr, 32'h0010_0093);
        req_imm = 32'd2;
        @(posedge clk); #1;
        check("full ready", {31'd0, req_ready}, 32'd0);
        check("full head", out_instr, 32'h0010_0093);
        req_imm = 32'd3;
        @(posedge clk); #1;
        check("stall head", out_instr, 32'h0010_0093);
        check("stall valid", {31'd0, out_valid}, 32'd1);
        check("stall ready", {31'd0, req_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        check("full no pass", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        exp_out++;
        check("drain1 head", out_instr, 32'h0020_0093);
        check("drain1 count", {16'd0, out_count}, exp_out);
        check("drain1 ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        exp_out++;
        req_valid = 1'b0;
        check("pushpop head", out_instr, 32'h0030_0093);
        check("pushpop count", {16'd0, out_count}, exp_out);
        @(posedge clk); #1;
        exp_out++;
        out_ready = 1'b0;
        check("drain3 valid", {31'd0, out_valid}, 32'd0);
        check("drain3 count", {16'd0, out_count}, exp_out);

        // err_count saturation: 260 rejected pushes streamed through
        set_req(6'd60, 5'd0, 5'd0, 5'd0, 32'd0);
        req_valid = 1'b1;
        out_ready = 1'b1;
        repeat (260) @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_out += 260;
        check("sat err_count", {24'd0, err_count}, 32'd255);
        check("sat out_count", {16'd0, out_count}, exp_out);

        // Reset with two entries held
        set_req(6'd21, 5'd2, 5'd0, 5'd0, 32'd9);
        req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("pre-rst full", {31'd0, req_ready}, 32'd0);
        check("pre-rst valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("midrst valid", {31'd0, out_valid}, 32'd0);
        check("midrst out_count", {16'd0, out_count}, 32'd0);
        check("midrst err_count", {24'd0, err_count}, 32'd0);
        check("midrst instr", out_instr, 32'd0);
        check("midrst ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("after rst ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check("discarded", {31'd0, out_valid}, 32'd0);
        check("no partial pop", {16'd0, out_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
